// File: rtl/npc_predict.sv
// npc_predict: fetch-stage next-PC unit.
// Holds the fetch PC and picks the next fetch address. The candidates, in
// priority order, are reset, a back-end redirect, a stall hold, a BTB
// prediction, and pc+4. The BTB is direct-mapped and each entry carries a
// 2-bit saturating direction counter. Resolved branches from execute train it.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   stall           hold pc (redirects and training still proceed)
//   pc              registered fetch address
//   pc4             pc + 4 (wraps)
//   pred_taken      BTB hit at pc with counter >= 2
//   pred_target     BTB target at pc, 0 on miss
//   res_valid       a control transfer resolved this cycle
//   res_pc          address of the resolved instruction
//   res_taken       actual direction
//   res_target      actual taken target
//   res_mispredict  wrong-path fetch; redirect (qualified by res_valid)
module npc_predict #(
  parameter int unsigned     WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned     BTB_ENTRIES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc4,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_pc,
  input  logic             res_taken,
  input  logic [WIDTH-1:0] res_target,
  input  logic             res_mispredict
);

  localparam int unsigned IDX_BITS = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W    = WIDTH - IDX_BITS - 2;
  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [1:0]             btb_ctr    [BTB_ENTRIES];
  logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
  logic [WIDTH-1:0]       btb_target [BTB_ENTRIES];

  logic [IDX_BITS-1:0] pc_idx;
  logic [TAG_W-1:0]    pc_tag;
  logic                pc_hit;
  logic [IDX_BITS-1:0] res_idx;
  logic [TAG_W-1:0]    res_tag;
  logic                res_hit;
  logic [WIDTH-1:0]    next_pc;

  // Lookup on the current fetch PC
  always_comb begin
    pc_idx      = pc[IDX_BITS+1:2];
    pc_tag      = pc[WIDTH-1:IDX_BITS+2];
    pc_hit      = btb_valid[pc_idx] && (btb_tag[pc_idx] == pc_tag);
    pc4         = pc + FOUR;
    pred_taken  = pc_hit && btb_ctr[pc_idx][1];
    pred_target = pc_hit ? btb_target[pc_idx] : '0;
  end

  // Lookup on the resolving instruction, used for training
  always_comb begin
    res_idx = res_pc[IDX_BITS+1:2];
    res_tag = res_pc[WIDTH-1:IDX_BITS+2];
    res_hit = btb_valid[res_idx] && (btb_tag[res_idx] == res_tag);
  end

  always_comb begin
    next_pc = pc4;
    if (res_valid && res_mispredict)
      next_pc = res_taken ? res_target : res_pc + FOUR;
    else if (stall)
      next_pc = pc;
    else if (pred_taken)
      next_pc = pred_target;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else     pc <= next_pc;
  end

  // Valid bits and counters are reset. Tag and target need no reset because
  // an entry is meaningless until its valid bit is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_valid <= '0;
      btb_ctr   <= '{default: 2'd1};
    end else if (res_valid) begin
      if (res_hit) begin
        if (res_taken && btb_ctr[res_idx] != 2'd3)
          btb_ctr[res_idx] <= btb_ctr[res_idx] + 2'd1;
        else if (!res_taken && btb_ctr[res_idx] != 2'd0)
          btb_ctr[res_idx] <= btb_ctr[res_idx] - 2'd1;
      end else if (res_taken) begin
        btb_valid[res_idx] <= 1'b1;
        btb_ctr[res_idx]   <= 2'd2;
      end
    end
  end

  // On a hit the tag already matches, so rewriting it is harmless. This lets
  // the hit-update and allocate cases share a single write.
  always_ff @(posedge clk) begin
    if (res_valid && res_taken) begin
      btb_tag[res_idx]    <= res_tag;
      btb_target[res_idx] <= res_target;
    end
  end

endmodule

// File: tb/tb_npc_predict.sv
module tb_npc_predict;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] pc, pc4, pred_target;
  logic        pred_taken;
  logic        res_valid, res_taken, res_mispredict;
  logic [31:0] res_pc, res_target;

  int passed = 0;
  int total  = 0;

  // Reference model: the BTB is keyed by word address (pc >> 2), which is the
  // same as tag plus index. A direct-mapped slot is modelled by evicting any
  // other key that has the same key % 16.
  logic [31:0] m_pc;
  int unsigned m_ctr [int unsigned];
  logic [31:0] m_tgt [int unsigned];

  npc_predict #(.WIDTH(32), .RESET_PC(32'h100), .BTB_ENTRIES(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc(pc), .pc4(pc4),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .res_target(res_target), .res_mispredict(res_mispredict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic m_reset();
    m_ctr.delete();
    m_tgt.delete();
    m_pc = 32'h100;
  endtask

  task automatic m_look(input logic [31:0] a, output bit hit, output bit tk,
                        output logic [31:0] tg);
    int unsigned k;
    k = a >> 2;
    hit = m_ctr.exists(k);
    tk = 1'b0;
    tg = '0;
    if (hit) begin
      tk = (m_ctr[k] >= 2);
      tg = m_tgt[k];
    end
  endtask

  task automatic m_train(input logic [31:0] rp, input bit rt, input logic [31:0] rg);
    int unsigned k;
    int unsigned victim;
    bit found;
    k = rp >> 2;
    if (m_ctr.exists(k)) begin
      if (rt) begin
        m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
        m_tgt[k] = rg;
      end else begin
        m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
      end
    end else if (rt) begin
      found = 1'b0;
      victim = 0;
      foreach (m_ctr[j]) if ((j % 16) == (k % 16)) begin victim = j; found = 1'b1; end
      if (found) begin m_ctr.delete(victim); m_tgt.delete(victim); end
      m_ctr[k] = 2;
      m_tgt[k] = rg;
    end
  endtask

  // One clock: drive inputs, check outputs against the model mid-cycle, then
  // advance the model across the edge.
  task automatic step(input bit st, input bit rv, input logic [31:0] rp, input bit rt,
                      input logic [31:0] rg, input bit rm);
    bit hit, tk;
    logic [31:0] tg, nxt;
    stall = st; res_valid = rv; res_pc = rp; res_taken = rt;
    res_target = rg; res_mispredict = rm;
    @(negedge clk);
    m_look(m_pc, hit, tk, tg);
    chk("pc", pc, m_pc);
    chk("pc4", pc4, m_pc + 32'd4);
    chk("pred_taken", {31'b0, pred_taken}, {31'b0, tk});
    chk("pred_target", pred_target, tg);
    if (rv && rm)   nxt = rt ? rg : rp + 32'd4;
    else if (st)    nxt = m_pc;
    else if (tk)    nxt = tg;
    else            nxt = m_pc + 32'd4;
    if (rv) m_train(rp, rt, rg);
    @(posedge clk);
    #1;
    m_pc = nxt;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  // Redirect fetch to a via a not-taken mispredict at a-4 (untrained address)
  task automatic go(input logic [31:0] a);
    step(1'b0, 1'b1, a - 32'd4, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    logic [31:0] rp, rg;
    rst = 1'b1; stall = 1'b0; res_valid = 1'b0; res_pc = '0;
    res_taken = 1'b0; res_target = '0; res_mispredict = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", pc, 32'h100);
    chk("reset_pc4", pc4, 32'h104);
    chk("reset_pred_taken", {31'b0, pred_taken}, 32'h0);
    chk("reset_pred_target", pred_target, 32'h0);
    rst = 1'b0;

    // Sequential fetch after reset
    idle(); chk("seq_104", pc, 32'h104);
    idle(); chk("seq_108", pc, 32'h108);

    // Stall holds, then resumes
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); chk("stall_1", pc, 32'h108);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); chk("stall_2", pc, 32'h108);
    idle(); chk("stall_resume", pc, 32'h10C);

    // Mispredict-train 0x200 -> 0x400
    step(1'b0, 1'b1, 32'h200, 1'b1, 32'h400, 1'b1); chk("train_redirect", pc, 32'h400);
    go(32'h200);
    chk("hit_pred_taken", {31'b0, pred_taken}, 32'h1);
    chk("hit_pred_target", pred_target, 32'h400);
    idle(); chk("hit_follow", pc, 32'h400);

    // Counter saturation, then decay to 1, then restore
    repeat (3) step(1'b0, 1'b1, 32'h200, 1'b1, 32'h400, 1'b0);
    repeat (2) step(1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
    go(32'h200);
    chk("weak_pred_taken", {31'b0, pred_taken}, 32'h0);
    idle(); chk("weak_follow", pc, 32'h204);
    step(1'b0, 1'b1, 32'h200, 1'b1, 32'h400, 1'b0);
    go(32'h200);
    chk("restore_pred_taken", {31'b0, pred_taken}, 32'h1);

    // Alias eviction: 0x240 shares index 0 with 0x200
    step(1'b0, 1'b1, 32'h240, 1'b1, 32'h500, 1'b0);
    go(32'h200);
    chk("evicted_pred_taken", {31'b0, pred_taken}, 32'h0);
    chk("evicted_pred_target", pred_target, 32'h0);
    go(32'h240);
    chk("alias_pred_taken", {31'b0, pred_taken}, 32'h1);
    chk("alias_pred_target", pred_target, 32'h500);

    // Redirect under stall; the same-index lookup still sees the old entry
    stall = 1'b1; res_valid = 1'b1; res_pc = 32'h200; res_taken = 1'b1;
    res_target = 32'h80; res_mispredict = 1'b1;
    #1;
    chk("same_cycle_old_taken", {31'b0, pred_taken}, 32'h1);
    chk("same_cycle_old_target", pred_target, 32'h500);
    step(1'b1, 1'b1, 32'h200, 1'b1, 32'h80, 1'b1);
    chk("stall_redirect", pc, 32'h80);
    go(32'h240);
    chk("after_alloc_240", {31'b0, pred_taken}, 32'h0);
    go(32'h200);
    chk("after_alloc_200", pred_target, 32'h80);

    // Mispredict without res_valid is ignored
    go(32'h600);
    step(1'b0, 1'b0, 32'h200, 1'b1, 32'h900, 1'b1);
    chk("ignored_mispredict", pc, 32'h604);

    // Wraparound of pc+4 and res_pc+4
    go(32'hFFFF_FFFC);
    chk("wrap_pc4", pc4, 32'h0);
    idle(); chk("wrap_pc", pc, 32'h0);
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1);
    chk("wrap_res_pc4", pc, 32'h0);

    // Asynchronous reset mid-cycle; same-cycle training is discarded
    res_valid = 1'b1; res_pc = 32'h300; res_taken = 1'b1;
    res_target = 32'h340; res_mispredict = 1'b1; stall = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pc", pc, 32'h100);
    chk("async_rst_pred", {31'b0, pred_taken}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    res_valid = 1'b0;
    m_reset();
    go(32'h300);
    chk("rst_discard_train", {31'b0, pred_taken}, 32'h0);
    go(32'h200);
    chk("rst_cleared_btb", {31'b0, pred_taken}, 32'h0);

    // Randomized traffic over a small address pool to force hits and aliases
    for (int n = 0; n < 400; n++) begin
      rp = 32'h1000 + 32'd4 * $urandom_range(0, 47);
      rg = 32'h1000 + 32'd4 * $urandom_range(0, 47);
      if ($urandom_range(0, 7) == 0) rg = rg | 32'($urandom_range(0, 3));
      step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, rp,
           $urandom_range(0, 2) != 0, rg, $urandom_range(0, 9) < 3);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/npc_predict.md
# npc_predict

Parametrised next-PC unit with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It sits at the head of the fetch stage. It holds the fetch PC register and each cycle selects the next fetch address from reset, a back-end redirect, stall-hold, a BTB prediction, or PC+4. Branch resolution from execute trains the BTB and corrects mispredictions.

## Interface
- WIDTH, 32: address width in bits; must be ≥ 2+IDX_BITS+1.
- RESET_PC, 0: value loaded into `pc` on reset.
- BTB_ENTRIES, 16: BTB depth; power of two, ≥ 2. IDX_BITS = log2(BTB_ENTRIES).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  hold `pc` this cycle; does not block redirect or BTB training.
- pc  out  WIDTH  current fetch address (registered).
- pc4  out  WIDTH  `pc`+4, modulo 2^WIDTH (combinational).
- pred_taken  out  1  BTB hit with counter ≥ 2 for the current `pc` (combinational).
- pred_target  out  WIDTH  BTB target for the current `pc`; 0 when no hit.
- res_valid  in  1  a control-transfer instruction resolved this cycle.
- res_pc  in  WIDTH  address of the resolved instruction.
- res_taken  in  1  actual direction.
- res_target  in  WIDTH  actual taken target (meaningful when `res_taken`=1).
- res_mispredict  in  1  front end fetched the wrong path; redirect. Only sampled when `res_valid`=1.

## Operation
- BTB entry fields: valid, tag = addr[WIDTH-1:IDX_BITS+2], target[WIDTH-1:0], ctr[1:0]. Index = addr[IDX_BITS+1:2]. addr[1:0] are ignored for indexing.
- Lookup is combinational on `pc`. A hit requires valid and a tag match.
- Next-PC priority, highest first:
  1. `rst`: `pc` ← RESET_PC.
  2. `res_valid & res_mispredict`: `pc` ← `res_taken` ? `res_target` : `res_pc`+4. This overrides `stall`.
  3. `stall`: `pc` ← `pc`.
  4. `pred_taken`: `pc` ← `pred_target`.
  5. Otherwise `pc` ← `pc4`.
- Training happens on `res_valid`, independent of `stall` and `res_mispredict`:
  - Hit at `res_pc`, taken: ctr ← min(ctr+1, 3); target ← `res_target`.
  - Hit at `res_pc`, not taken: ctr ← max(ctr−1, 0); target unchanged.
  - Miss, taken: allocate, overwriting any occupant. Set valid=1, tag, target=`res_target`, ctr=2.
  - Miss, not taken: no change.
- Reset clears all valid bits and sets all ctr to 1. Target and tag are don't-care.
- Adding 4 to the PC wraps modulo 2^WIDTH. No alignment check is applied to `res_target`.

## Timing
- `pc` is updated one cycle after the select inputs; the redirect takes effect at the next edge.
- BTB writes are visible to lookup on the cycle after `res_valid`. There is no write-to-read bypass: a same-index lookup in the update cycle sees the old contents.
- Reset values: `pc`=RESET_PC, `pc4`=RESET_PC+4, `pred_taken`=0, `pred_target`=0.
- Asserting `rst` mid-operation immediately (asynchronously) forces `pc` and clears the BTB. Any `res_*` input in the same cycle is discarded.
- In the first edge after `rst` deasserts, normal selection applies. An empty BTB gives `pc` ← `pc4`.
- Simultaneous mispredict and `stall`: redirect wins, and training still occurs.
- `res_mispredict` with `res_valid`=0 is ignored.

## Test plan
- Reset with RESET_PC=0x100, no other inputs for 3 cycles: `pc` goes 0x100 → 0x104 → 0x108, and `pred_taken`=0 throughout.
- `stall`=1 for 2 cycles at `pc`=0x108: `pc` holds at 0x108, then resumes at 0x10C.
- Train: `res_valid`=1, `res_pc`=0x200, `res_taken`=1, `res_target`=0x400, `res_mispredict`=1. Required:
  - next `pc`=0x400;
  - later, fetching 0x200 gives `pred_taken`=1 and `pred_target`=0x400, and the following `pc`=0x400.
- Counter saturation at 0x200: 3 taken resolutions keep ctr=3. Two not-taken resolutions bring ctr to 1, so `pred_taken`=0 at 0x200 and next `pc`=0x204. One taken resolution restores the prediction.
- Alias eviction, BTB_ENTRIES=16: train 0x200 taken, then train 0x240 taken (same index, different tag). Fetching 0x200 then misses; fetching 0x240 hits.
- Redirect during `stall`, plus same-cycle lookup: `stall`=1 with a mispredict to 0x80 gives `pc`=0x80. A same-index lookup during the allocating cycle still reports the old entry.
